// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid-register stage family.
// Holds the occupancy state encoding and the default NOP instruction word
// used when building payload reset values at instantiation sites.
package pipe_pkg;

  // Width of the occupancy state register, which doubles as the occupancy count.
  localparam int STATE_W = 2;

  // Occupancy states; the numeric value equals the number of held entries.
  localparam logic [STATE_W-1:0] ST_EMPTY = 2'd0;
  localparam logic [STATE_W-1:0] ST_ONE   = 2'd1;
  localparam logic [STATE_W-1:0] ST_TWO   = 2'd2;

  // Default instruction encoding for a bubble; an IF/ID instance can build
  // its NOP_VAL as {pc_reset, INST_NOP}.
  localparam logic [31:0] INST_NOP = 32'h0;

endpackage : pipe_pkg

// File: rtl/pipe_skid_reg.sv
// Parametrised pipeline stage register with a 2-entry skid buffer.
// Upstream and downstream use valid/ready handshakes. in_ready depends only
// on registered state, so there is no combinational path from out_ready to
// in_ready, yet one entry per cycle can stream through when downstream is
// ready. freeze stalls the downstream transfer; flush discards all held
// entries and the current input, leaving a bubble.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [DATA_W-1:0]  main_q;
  logic [DATA_W-1:0]  main_d;
  logic [DATA_W-1:0]  skid_q;
  logic [DATA_W-1:0]  skid_d;

  logic in_fire;
  logic out_fire;

  // Outputs come straight from registered state: the head entry drives
  // out_data, and readiness reflects whether the skid slot is still free.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_TWO);
  assign occupancy = state_q;
  assign out_data  = main_q;

  // A downstream transfer needs the stage not frozen in addition to the handshake.
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ~freeze;

  // Next-state and payload selection for the handshake case; flush and
  // reset override this result in the register block below.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = ST_TWO;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
          main_d  = NOP_VAL;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
          skid_d  = NOP_VAL;
        end
      end
      default: begin
        // Unreachable encoding: fall back to an empty, clean stage.
        state_d = ST_EMPTY;
        main_d  = NOP_VAL;
        skid_d  = NOP_VAL;
      end
    endcase
  end

  // State registers with reset taking priority over flush, and flush over the handshake.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomised checks for pipe_skid_reg (DATA_W=64, NOP_VAL=0).
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic [1:0]  occupancy;

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] sb_q[$];
  logic        exp_in_fire;
  logic        exp_out_fire;

  pipe_skid_reg #(.DATA_W(64), .NOP_VAL(64'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic v, input logic r,
                           input logic [1:0] occ, input logic [63:0] d);
    chk({tag, "_valid"}, {63'b0, out_valid}, {63'b0, v});
    chk({tag, "_ready"}, {63'b0, in_ready},  {63'b0, r});
    chk({tag, "_occ"},   {62'b0, occupancy}, {62'b0, occ});
    chk({tag, "_data"},  out_data, d);
  endtask

  initial begin
    // 1. Reset with a valid input present
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_data = 64'hAAAA; out_ready = 1'b0;
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    chk_state("reset", 1'b0, 1'b1, 2'd0, 64'h0);

    // 2. Streaming through at one entry per cycle
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 64'h10; step(); chk_state("stream0", 1'b1, 1'b1, 2'd1, 64'h10);
    in_data = 64'h11; step(); chk_state("stream1", 1'b1, 1'b1, 2'd1, 64'h11);
    in_data = 64'h12; step(); chk_state("stream2", 1'b1, 1'b1, 2'd1, 64'h12);
    in_valid = 1'b0;  step(); chk_state("stream_drain", 1'b0, 1'b1, 2'd0, 64'h0);

    // 3. Backpressure fills the skid slot, then drains in order
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 64'h20; step(); chk_state("bp0", 1'b1, 1'b1, 2'd1, 64'h20);
    in_data = 64'h21; step(); chk_state("bp1", 1'b1, 1'b0, 2'd2, 64'h20);
    in_data = 64'h22; step(); chk_state("bp_hold", 1'b1, 1'b0, 2'd2, 64'h20);
    out_ready = 1'b1; step(); chk_state("bp_out21", 1'b1, 1'b1, 2'd1, 64'h21);
    step(); in_valid = 1'b0;  chk_state("bp_out22", 1'b1, 1'b1, 2'd1, 64'h22);
    step();                   chk_state("bp_empty", 1'b0, 1'b1, 2'd0, 64'h0);

    // 4. Freeze holds the head entry despite out_ready
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h30; step();
    in_valid = 1'b0; freeze = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state("freeze", 1'b1, 1'b1, 2'd1, 64'h30);
    end
    freeze = 1'b0; step();
    chk_state("unfreeze", 1'b0, 1'b1, 2'd0, 64'h0);

    // 5. Flush with two entries and a new input
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 64'h40; step();
    in_data = 64'h41; step();
    chk_state("pre_flush", 1'b1, 1'b0, 2'd2, 64'h40);
    flush = 1'b1; in_data = 64'h42; step();
    chk_state("flush", 1'b0, 1'b1, 2'd0, 64'h0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    chk_state("post_flush", 1'b0, 1'b1, 2'd0, 64'h0);

    // 6. Reset and flush together with an accepted input
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h50; step();
    chk_state("pre_rst", 1'b1, 1'b1, 2'd1, 64'h50);
    rst = 1'b1; flush = 1'b1; in_data = 64'h51; step();
    chk_state("rst_flush", 1'b0, 1'b1, 2'd0, 64'h0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

    // Random traffic against a scoreboard queue
    sb_q.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      freeze    = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 49) == 0);
      #1;
      exp_in_fire  = in_valid & in_ready;
      exp_out_fire = out_valid & out_ready & ~freeze;
      if (exp_out_fire) begin
        if (sb_q.size() == 0) begin
          chk("rand_underflow", {63'b0, out_valid}, 64'h0);
        end else begin
          chk("rand_order", out_data, sb_q[0]);
          void'(sb_q.pop_front());
        end
      end
      if (flush) sb_q.delete();
      else if (exp_in_fire) sb_q.push_back(in_data);
      step();
      chk("rand_occ", {62'b0, occupancy}, 64'(sb_q.size()));
    end
    flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_pipe_skid_reg
